// File: rtl/main_memory_responder.sv
// main_memory_responder: memory-side responder for the serialised memory access port.
// Reads return in accept order after READ_LATENCY cycles, tagged with a serial. Writes
// complete after WRITE_LATENCY cycles with a completion response.
// Optional macro RSD_MEM_RESPONDER_JITTER_EN: an LFSR adds 0-3 cycles to each read's
// due time while keeping returns in order.
module main_memory_responder #(
  parameter int ENTRY_WIDTH        = 128,
  parameter int ADDR_WIDTH         = 32,
  parameter int INDEX_WIDTH        = 12,
  parameter int READ_SERIAL_WIDTH  = 4,
  parameter int WRITE_SERIAL_WIDTH = 4,
  parameter int READ_LATENCY       = 4,
  parameter int WRITE_LATENCY      = 2,
  parameter int MAX_READ_OUT       = 8,
  parameter int MAX_WRITE_OUT      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         memAccessAddr,
  input  logic [ENTRY_WIDTH-1:0]        memAccessWriteData,
  input  logic                          memAccessRE,
  input  logic                          memAccessWE,
  output logic                          memAccessReadBusy,
  output logic                          memAccessWriteBusy,
  output logic [READ_SERIAL_WIDTH-1:0]  nextMemReadSerial,
  output logic [WRITE_SERIAL_WIDTH-1:0] nextMemWriteSerial,
  output logic                          memReadDataReady,
  output logic [ENTRY_WIDTH-1:0]        memReadData,
  output logic [READ_SERIAL_WIDTH-1:0]  memReadSerial,
  output logic                          memAccessResponseValid,
  output logic [WRITE_SERIAL_WIDTH-1:0] memAccessResponseSerial,
  output logic                          protocolError
);
  localparam int OFFSET  = $clog2(ENTRY_WIDTH / 8);
  localparam int ENTRIES = 2 ** INDEX_WIDTH;
  localparam int TW      = 16;  // cycle stamp width; due times are compared modulo 2**TW
  localparam int RPW     = (MAX_READ_OUT > 1) ? $clog2(MAX_READ_OUT) : 1;
  localparam int WPW     = (MAX_WRITE_OUT > 1) ? $clog2(MAX_WRITE_OUT) : 1;
  localparam int RCW     = $clog2(MAX_READ_OUT + 1);
  localparam int WCW     = $clog2(MAX_WRITE_OUT + 1);

  typedef logic [TW-1:0] stamp_t;

  logic [ENTRY_WIDTH-1:0] mem [ENTRIES];

  // In-order return queues: every entry carries the cycle stamp at which it is presented.
  logic [ENTRY_WIDTH-1:0]        rdData [MAX_READ_OUT];
  logic [READ_SERIAL_WIDTH-1:0]  rdSer  [MAX_READ_OUT];
  stamp_t                        rdDue  [MAX_READ_OUT];
  logic [RPW-1:0]                rdHead, rdTail;
  logic [RCW-1:0]                rdCount;
  logic [WRITE_SERIAL_WIDTH-1:0] wrSer  [MAX_WRITE_OUT];
  stamp_t                        wrDue  [MAX_WRITE_OUT];
  logic [WPW-1:0]                wrHead, wrTail;
  logic [WCW-1:0]                wrCount;

  stamp_t                 now;
  stamp_t                 rdNewDue, wrNewDue;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   acceptRead, acceptWrite, reqError, rdPop, wrPop;
  logic                   unusedAddrBits;

  // Offset and high address bits are intentionally dropped (aliasing).
  assign unusedAddrBits = ^memAccessAddr;
  assign idx            = memAccessAddr[OFFSET +: INDEX_WIDTH];

  assign memAccessReadBusy  = (rdCount == RCW'(MAX_READ_OUT));
  assign memAccessWriteBusy = (wrCount == WCW'(MAX_WRITE_OUT));

  // Write wins over a simultaneous read; nothing is accepted on a reset edge.
  assign acceptWrite = rst & memAccessWE & ~memAccessWriteBusy;
  assign acceptRead  = rst & memAccessRE & ~memAccessWE & ~memAccessReadBusy;
  assign reqError    = (memAccessRE & memAccessWE) | (memAccessRE & memAccessReadBusy) |
                       (memAccessWE & memAccessWriteBusy);

  // Head of each queue is presented exactly in the cycle its stamp matches.
  assign rdPop = (rdCount != '0) && (rdDue[rdHead] == now);
  assign wrPop = (wrCount != '0) && (wrDue[wrHead] == now);

  assign memReadDataReady        = rdPop;
  assign memReadData             = rdPop ? rdData[rdHead] : '0;
  assign memReadSerial           = rdPop ? rdSer[rdHead] : '0;
  assign memAccessResponseValid  = wrPop;
  assign memAccessResponseSerial = wrPop ? wrSer[wrHead] : '0;

  assign wrNewDue = now + stamp_t'(WRITE_LATENCY);

`ifdef RSD_MEM_RESPONDER_JITTER_EN
  logic [15:0] lfsr;
  stamp_t      ownDue, predDue, rdLastDue;
  logic [TW-1:0] dueGap;

  // Jittered due time, pushed past the predecessor so returns stay in order.
  assign ownDue   = now + stamp_t'(READ_LATENCY) + stamp_t'(lfsr[1:0]);
  assign predDue  = rdLastDue + 1'b1;
  assign dueGap   = predDue - ownDue;
  assign rdNewDue = ((rdCount != '0) && !dueGap[TW-1] && (dueGap != '0)) ? predDue : ownDue;

  // Free-running LFSR (taps 16,14,13,11) and the due time of the youngest read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr      <= 16'hACE1;
      rdLastDue <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (acceptRead) rdLastDue <= rdNewDue;
    end
  end
`else
  assign rdNewDue = now + stamp_t'(READ_LATENCY);
`endif

  // Entry array: read-before-write is moot since a read and a write never share a cycle.
  always_ff @(posedge clk) begin
    if (acceptWrite) mem[idx] <= memAccessWriteData;
  end

  // Queue payload storage; validity is tracked by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (acceptRead) begin
      rdData[rdTail] <= mem[idx];
      rdSer[rdTail]  <= nextMemReadSerial;
      rdDue[rdTail]  <= rdNewDue;
    end
    if (acceptWrite) begin
      wrSer[wrTail] <= nextMemWriteSerial;
      wrDue[wrTail] <= wrNewDue;
    end
  end

  // Control state: cycle stamp, queue pointers/counts, serial counters, sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      now                <= '0;
      rdHead             <= '0;
      rdTail             <= '0;
      rdCount            <= '0;
      wrHead             <= '0;
      wrTail             <= '0;
      wrCount            <= '0;
      nextMemReadSerial  <= '0;
      nextMemWriteSerial <= '0;
      protocolError      <= 1'b0;
    end else begin
      now <= now + 1'b1;
      if (reqError) protocolError <= 1'b1;
      if (acceptRead) begin
        rdTail            <= (rdTail == RPW'(MAX_READ_OUT - 1)) ? '0 : rdTail + 1'b1;
        nextMemReadSerial <= nextMemReadSerial + 1'b1;
      end
      if (rdPop) rdHead <= (rdHead == RPW'(MAX_READ_OUT - 1)) ? '0 : rdHead + 1'b1;
      rdCount <= rdCount + RCW'(acceptRead) - RCW'(rdPop);
      if (acceptWrite) begin
        wrTail             <= (wrTail == WPW'(MAX_WRITE_OUT - 1)) ? '0 : wrTail + 1'b1;
        nextMemWriteSerial <= nextMemWriteSerial + 1'b1;
      end
      if (wrPop) wrHead <= (wrHead == WPW'(MAX_WRITE_OUT - 1)) ? '0 : wrHead + 1'b1;
      wrCount <= wrCount + WCW'(acceptWrite) - WCW'(wrPop);
    end
  end
endmodule
